ajuste_tempo_ctrl: RTL and testbench

Parametrised time-setting controller for the digital clock. It captures N time fields one at a time from the slide switches, steps through them on edges of the `set` button, and range-checks every entry. It drives per-field blink/blank flags for the display and emits a one-cycle `adjust` pulse that loads the committed time into the running counter. It sits between the switch/button inputs and the timekeeping core.

---
 rtl/ajuste_tempo_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ajuste_tempo_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ajuste_tempo_ctrl.sv
// ajuste_tempo_ctrl: time-setting controller for the digital clock.
// It captures NFIELDS fields one at a time from the switches on rising edges
// of `set` and range-checks each entry. Per-field blink flags go to the
// display, and a one-cycle `adjust` strobe loads the staged time into the
// timekeeping core.
// Optional feature macro: AJUSTE_TIMEOUT_EN. When it is defined, edit mode
// aborts after TIMEOUT_CYC cycles without a press and pulses `expirou`.
//
// Handshake: the block has no valid/ready pair. `adjust`, `erro` and
// `expirou` are single-cycle strobes from registers. `tempo` is stable
// whenever `adjust` is high, and `erro`/`expirou` never coincide with `adjust`.
module ajuste_tempo_ctrl #(
  parameter int NFIELDS     = 3,
  parameter int FW          = 6,
  parameter int MAX_HI      = 23,
  parameter int MAX_LO      = 59,
  parameter int BLINK_DIV   = 25_000_000,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [FW-1:0]              sw,
  input  logic                       set,
  input  logic                       modo_ajuste,
  input  logic [NFIELDS*FW-1:0]      cur_time,
  output logic [NFIELDS*FW-1:0]      tempo,
  output logic                       adjust,
  output logic                       busy,
  output logic [$clog2(NFIELDS)-1:0] campo_sel,
  output logic [NFIELDS-1:0]         blank,
  output logic                       erro,
  output logic                       expirou,
  output logic [1:0]                 state_dbg
);

  localparam int SELW    = $clog2(NFIELDS);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EDIT   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] WAIT   = 2'd3;

  localparam logic [FW-1:0]      MAX_HI_F   = FW'(MAX_HI);
  localparam logic [FW-1:0]      MAX_LO_F   = FW'(MAX_LO);
  localparam logic [SELW-1:0]    LAST_SEL   = SELW'(NFIELDS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Reject configurations the range check and counters cannot represent.
  if (MAX_HI >= (1 << FW) || MAX_LO >= (1 << FW) || BLINK_DIV < 1 || TIMEOUT_CYC < 1)
  begin : g_bad_cfg
    $error("ajuste_tempo_ctrl: illegal parameter set");
  end

  logic [1:0]            state;
  logic                  set_prev;
  logic                  phase;
  logic [BLINK_W-1:0]    blink_cnt;
  logic                  press;
  logic [FW-1:0]         field_max;
  logic [NFIELDS*FW-1:0] tempo_next;

  assign press     = set && !set_prev;
  assign busy      = (state == EDIT) || (state == COMMIT);
  assign state_dbg = state;

  // The limit depends on the field being edited: field 0 holds hours.
  always_comb begin
    field_max = (campo_sel == '0) ? MAX_HI_F : MAX_LO_F;
  end

  // Staged time with the field currently selected replaced by the switches.
  always_comb begin
    tempo_next = tempo;
    for (int i = 0; i < NFIELDS; i++) begin
      if (campo_sel == SELW'(i)) begin
        tempo_next[(NFIELDS-1-i)*FW +: FW] = sw;
      end
    end
  end

  // Only the field being edited blinks, and only while editing.
  always_comb begin
    blank = '0;
    if (state == EDIT) begin
      for (int i = 0; i < NFIELDS; i++) begin
        if (campo_sel == SELW'(i)) begin
          blank[i] = phase;
        end
      end
    end
  end

`ifdef AJUSTE_TIMEOUT_EN
  localparam int             TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] inact_cnt;
`else
  assign expirou = 1'b0;
`endif

  // Main FSM: field capture, blink timing, strobes and button edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tempo     <= '0;
      adjust    <= 1'b0;
      campo_sel <= '0;
      erro      <= 1'b0;
      phase     <= 1'b0;
      blink_cnt <= '0;
      set_prev  <= 1'b1;
`ifdef AJUSTE_TIMEOUT_EN
      expirou   <= 1'b0;
      inact_cnt <= '0;
`endif
    end else begin
      set_prev <= set;
      adjust   <= 1'b0;
      erro     <= 1'b0;
`ifdef AJUSTE_TIMEOUT_EN
      expirou  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (modo_ajuste) begin
            state     <= EDIT;
            tempo     <= cur_time;
            campo_sel <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
`ifdef AJUSTE_TIMEOUT_EN
            inact_cnt <= '0;
`endif
          end
        end
        EDIT: begin
          if (!modo_ajuste) begin
            // Abort wins over a simultaneous press; partial values stay.
            state <= IDLE;
          end else begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              phase     <= ~phase;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
            if (press) begin
`ifdef AJUSTE_TIMEOUT_EN
              inact_cnt <= '0;
`endif
              if (sw <= field_max) begin
                tempo     <= tempo_next;
                blink_cnt <= '0;
                phase     <= 1'b0;
                if (campo_sel == LAST_SEL) begin
                  state  <= COMMIT;
                  adjust <= 1'b1;
                end else begin
                  campo_sel <= campo_sel + 1'b1;
                end
              end else begin
                erro <= 1'b1;
              end
            end
`ifdef AJUSTE_TIMEOUT_EN
            else if (inact_cnt == TO_LAST) begin
              state   <= IDLE;
              expirou <= 1'b1;
            end else begin
              inact_cnt <= inact_cnt + 1'b1;
            end
`endif
          end
        end
        COMMIT: state <= WAIT;
        WAIT: begin
          if (!modo_ajuste) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ajuste_tempo_ctrl.sv
// Testbench for ajuste_tempo_ctrl with BLINK_DIV=4 and TIMEOUT_CYC=100.
// Strobe events (adjust/erro/expirou) are queued by the stimulus and checked
// by an independent monitor; level outputs are checked directly.
module tb_ajuste_tempo_ctrl;
  localparam int NF = 3;
  localparam int FW = 6;
  localparam int TW = NF * FW;
  localparam int EW = 3 + TW + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EDIT = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] sw;
  logic          set;
  logic          modo_ajuste;
  logic [TW-1:0] cur_time;
  logic [TW-1:0] tempo;
  logic          adjust;
  logic          busy;
  logic [1:0]    campo_sel;
  logic [NF-1:0] blank;
  logic          erro;
  logic          expirou;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  ajuste_tempo_ctrl #(
    .NFIELDS(NF), .FW(FW), .MAX_HI(23), .MAX_LO(59),
    .BLINK_DIV(4), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .set(set), .modo_ajuste(modo_ajuste),
    .cur_time(cur_time), .tempo(tempo), .adjust(adjust), .busy(busy),
    .campo_sel(campo_sel), .blank(blank), .erro(erro), .expirou(expirou),
    .state_dbg(state_dbg)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL sim_timeout act=running exp=finished");
    $fatal(1, "time limit");
  end

  function automatic logic [EW-1:0] ev(input logic [2:0] flags, input logic [TW-1:0] t,
                                       input logic [1:0] c);
    return {flags, t, c};
  endfunction

  function automatic logic [TW-1:0] hms(input int h, input int m, input int s);
    return {FW'(h), FW'(m), FW'(s)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic press(input int v);
    sw  = FW'(v);
    set = 1'b1;
    tick();
    set = 1'b0;
    tick();
  endtask

  // Monitor: every strobe cycle must match the next queued event.
  always @(negedge clk) begin
    if (!reset && (adjust || erro || expirou)) begin
      logic [EW-1:0] got;
      logic [EW-1:0] want;
      got = ev({adjust, erro, expirou}, tempo, campo_sel);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe act=%0h exp=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL strobe_event act=%0h exp=%0h", got, want);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; set = 1'b1; modo_ajuste = 1'b0; sw = '0;
    cur_time = hms(12, 34, 56);

    // Reset with the button held.
    repeat (3) tick();
    samp();
    chk("rst_tempo", 32'(tempo), 0);
    chk("rst_campo", 32'(campo_sel), 0);
    chk("rst_outs", {blank, adjust, busy, erro, expirou}, 0);
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    reset = 1'b0;
    repeat (3) tick();
    samp();
    chk("post_rst_outs", {tempo, campo_sel, blank, adjust, busy, erro}, 0);
    set = 1'b0;
    tick();

    // Full entry 07:08:09 and commit.
    modo_ajuste = 1'b1;
    tick();
    samp();
    chk("entry_tempo", 32'(tempo), 32'(hms(12, 34, 56)));
    chk("entry_busy", 32'(busy), 1);
    press(7);
    samp();
    chk("f0_campo", 32'(campo_sel), 1);
    chk("f0_tempo", 32'(tempo), 32'(hms(7, 34, 56)));
    press(8);
    samp();
    chk("f1_campo", 32'(campo_sel), 2);
    exp_q.push_back(ev(3'b100, hms(7, 8, 9), 2'd2));
    press(9);
    repeat (4) tick();
    samp();
    chk("wait_state", 32'(state_dbg), 32'(S_WAIT));
    chk("wait_busy", 32'(busy), 0);
    chk("commit_tempo", 32'(tempo), 32'(hms(7, 8, 9)));
    modo_ajuste = 1'b0;
    tick();
    samp();
    chk("wait_exit", 32'(state_dbg), 32'(S_IDLE));

    // Range limits on fields 0 and 1, then abort.
    modo_ajuste = 1'b1;
    tick();
    exp_q.push_back(ev(3'b010, hms(12, 34, 56), 2'd0));
    press(24);
    samp();
    chk("rej24_campo", 32'(campo_sel), 0);
    press(23);
    samp();
    chk("acc23_campo", 32'(campo_sel), 1);
    exp_q.push_back(ev(3'b010, hms(23, 34, 56), 2'd1));
    press(60);
    samp();
    chk("rej60_campo", 32'(campo_sel), 1);
    press(59);
    samp();
    chk("acc59_tempo", 32'(tempo), 32'(hms(23, 59, 56)));
    modo_ajuste = 1'b0;
    tick();
    samp();
    chk("abort_state", 32'(state_dbg), 32'(S_IDLE));
    chk("abort_tempo", 32'(tempo), 32'(hms(23, 59, 56)));

    // Abort coinciding with a press: abort wins.
    modo_ajuste = 1'b1;
    tick();
    press(5);
    sw = 6'd7; set = 1'b1; modo_ajuste = 1'b0;
    tick();
    set = 1'b0;
    tick();
    samp();
    chk("abort_press_state", 32'(state_dbg), 32'(S_IDLE));
    chk("abort_press_tempo", 32'(tempo), 32'(hms(5, 34, 56)));

    // Blink on field 0, then phase restart after an accepted press.
    modo_ajuste = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      samp();
      chk($sformatf("blink0_%0d", k), 32'(blank), ((k / 4) % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    sw = 6'd1; set = 1'b1;
    tick();
    set = 1'b0;
    for (int j = 0; j < 8; j++) begin
      samp();
      chk($sformatf("blink1_%0d", j), 32'(blank), ((j / 4) % 2 == 1) ? 32'd2 : 32'd0);
      tick();
    end
    modo_ajuste = 1'b0;
    tick();
    samp();
    chk("idle_blank", 32'(blank), 0);

`ifdef AJUSTE_TIMEOUT_EN
    // Inactivity timeout: pulse in the 100th cycle after entry.
    begin
      int seen;
      seen = -1;
      modo_ajuste = 1'b1;
      exp_q.push_back(ev(3'b001, hms(12, 34, 56), 2'd0));
      tick();
      for (int k = 0; k < 200 && seen < 0; k++) begin
        samp();
        if (expirou) seen = k;
        tick();
      end
      chk("timeout_cycle", 32'(seen), 100);
      samp();
      chk("timeout_state", 32'(state_dbg), 32'(S_WAIT == 2'd3 ? S_IDLE : S_IDLE));
      modo_ajuste = 1'b0;
      tick();
    end
`endif

    repeat (2) tick();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
